lamp_arbiter: RTL and testbench

LAMP_ARBITER -- requirements
Module: lamp_arbiter

---
 rtl/lamp_pkg.sv | 39 +++
 rtl/lamp_prescaler.sv | 33 +++
 rtl/lamp_arbiter.sv | 174 +++++++++++++++++
 tb/tb_lamp_arbiter.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/lamp_pkg.sv
// Shared constants for the lamp arbiter: mode codes, step pattern table,
// default timing parameters and a saturating two-digit BCD increment.
package lamp_pkg;

   localparam int unsigned DEF_TICK_DIV  = 25000000;
   localparam int unsigned DEF_SEC_TICKS = 4;

   // Mode codes; 6 and 7 are never produced.
   localparam logic [2:0] MODE_IDLE   = 3'd0;
   localparam logic [2:0] MODE_LEFT   = 3'd1;
   localparam logic [2:0] MODE_RIGHT  = 3'd2;
   localparam logic [2:0] MODE_HAZARD = 3'd3;
   localparam logic [2:0] MODE_BRAKE  = 3'd4;
   localparam logic [2:0] MODE_DOOR   = 3'd5;

   // Step pattern table, entry 0 in the low slot: 001, 011, 111, 000.
   localparam logic [3:0][2:0] STEP_PAT = {3'b000, 3'b111, 3'b011, 3'b001};

   typedef struct packed {
      logic [3:0] tens;
      logic [3:0] units;
   } bcd2_t;

   // Two-digit BCD increment that sticks at 99.
   function automatic bcd2_t bcd_inc_sat(input bcd2_t v);
      bcd2_t r;
      r = v;
      if (v.tens == 4'd9 && v.units == 4'd9) begin
         r = v;
      end else if (v.units == 4'd9) begin
         r.units = 4'd0;
         r.tens  = v.tens + 4'd1;
      end else begin
         r.units = v.units + 4'd1;
      end
      return r;
   endfunction

endpackage

// File: rtl/lamp_prescaler.sv
// Step-tick prescaler: counts 0..TICK_DIV-1, strobes tick on the last count.
// A clear restarts the count so the next step lasts a full period.
module lamp_prescaler
   import lamp_pkg::*;
#(
   parameter int unsigned TICK_DIV = DEF_TICK_DIV
) (
   input  logic clk,
   input  logic rstN,
   input  logic clr,
   output logic tick
);

   localparam int unsigned       CNT_W   = $clog2(TICK_DIV);
   localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(TICK_DIV - 1);

   logic [CNT_W-1:0] r_cnt;

   // Free-running divider, cleared by reset, by clr and on wrap.
   always_ff @(posedge clk) begin
      if (!rstN) begin
         r_cnt <= '0;
      end else if (clr || (r_cnt == CNT_MAX)) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   // A clear in the same cycle wins over the strobe.
   assign tick = (r_cnt == CNT_MAX) && !clr;

endmodule

// File: rtl/lamp_arbiter.sv
// Lamp arbiter: synchronises four requests, picks a mode by priority and
// drives two 3-bit lamp groups plus a BCD door-open seconds timer.
// Mode, LEDs and the step counter all load from the same next-state logic,
// so a request edge shows up on every output exactly two clocks later.
module lamp_arbiter
   import lamp_pkg::*;
#(
   parameter int unsigned TICK_DIV  = DEF_TICK_DIV,
   parameter int unsigned SEC_TICKS = DEF_SEC_TICKS
) (
   input  logic       clk,
   input  logic       rstN,
   input  logic       reqL,
   input  logic       reqR,
   input  logic       reqBrake,
   input  logic       reqDoor,
   output logic [2:0] ledL,
   output logic [2:0] ledR,
   output logic [2:0] modeOut,
   output logic [3:0] doorTens,
   output logic [3:0] doorUnits,
   output logic       tick
);

   localparam int unsigned      SEC_W   = (SEC_TICKS > 1) ? $clog2(SEC_TICKS) : 1;
   localparam logic [SEC_W-1:0] SEC_MAX = SEC_W'(SEC_TICKS - 1);

   logic             r_req_l, r_req_r, r_req_brake, r_req_door;
   logic [2:0]       r_mode;
   logic [1:0]       r_step;
   logic [2:0]       r_led_l, r_led_r;
   logic [SEC_W-1:0] r_sec_cnt;
   bcd2_t            r_door_bcd;

   logic [2:0]       w_mode_next;
   logic             w_mode_chg;
   logic             w_tick;
   logic [1:0]       w_step_next;
   logic [2:0]       w_pat;
   logic [2:0]       w_brake_val;
   logic [2:0]       w_led_l_next, w_led_r_next;

   // Single register stage on every request input.
   always_ff @(posedge clk) begin
      if (!rstN) begin
         r_req_l     <= 1'b0;
         r_req_r     <= 1'b0;
         r_req_brake <= 1'b0;
         r_req_door  <= 1'b0;
      end else begin
         r_req_l     <= reqL;
         r_req_r     <= reqR;
         r_req_brake <= reqBrake;
         r_req_door  <= reqDoor;
      end
   end

   // Mode priority from the registered requests: DOOR > HAZARD > LEFT > RIGHT > BRAKE.
   always_comb begin
      w_mode_next = MODE_IDLE;
      if (r_req_door) begin
         w_mode_next = MODE_DOOR;
      end else if (r_req_l && r_req_r) begin
         w_mode_next = MODE_HAZARD;
      end else if (r_req_l) begin
         w_mode_next = MODE_LEFT;
      end else if (r_req_r) begin
         w_mode_next = MODE_RIGHT;
      end else if (r_req_brake) begin
         w_mode_next = MODE_BRAKE;
      end
   end

   assign w_mode_chg = (w_mode_next != r_mode);

   lamp_prescaler #(
      .TICK_DIV (TICK_DIV)
   ) u_prescaler (
      .clk  (clk),
      .rstN (rstN),
      .clr  (w_mode_chg),
      .tick (w_tick)
   );

   // Next step and lamp values; a mode change restarts the pattern at step 0.
   always_comb begin
      w_step_next  = r_step;
      w_led_l_next = 3'b000;
      w_led_r_next = 3'b000;
      if (w_mode_chg) begin
         w_step_next = 2'd0;
      end else if (w_tick) begin
         w_step_next = r_step + 2'd1;
      end
      w_pat       = STEP_PAT[w_step_next];
      w_brake_val = r_req_brake ? 3'b111 : 3'b000;
      case (w_mode_next)
         MODE_LEFT: begin
            w_led_l_next = w_pat;
            w_led_r_next = w_brake_val;
         end
         MODE_RIGHT: begin
            w_led_l_next = w_brake_val;
            w_led_r_next = w_pat;
         end
         MODE_HAZARD: begin
            w_led_l_next = w_pat;
            w_led_r_next = w_pat;
         end
         MODE_BRAKE: begin
            w_led_l_next = 3'b111;
            w_led_r_next = 3'b111;
         end
         MODE_DOOR: begin
            if (w_mode_chg) begin
               w_led_l_next = 3'b111;
               w_led_r_next = 3'b111;
            end else if (w_tick) begin
               w_led_l_next = ~r_led_l;
               w_led_r_next = ~r_led_r;
            end else begin
               w_led_l_next = r_led_l;
               w_led_r_next = r_led_r;
            end
         end
         default: begin
            w_led_l_next = 3'b000;
            w_led_r_next = 3'b000;
         end
      endcase
   end

   // Mode, step and lamp output registers.
   always_ff @(posedge clk) begin
      if (!rstN) begin
         r_mode  <= MODE_IDLE;
         r_step  <= 2'd0;
         r_led_l <= 3'b000;
         r_led_r <= 3'b000;
      end else begin
         r_mode  <= w_mode_next;
         r_step  <= w_step_next;
         r_led_l <= w_led_l_next;
         r_led_r <= w_led_r_next;
      end
   end

   // Door timer: cleared on DOOR entry, one BCD second per SEC_TICKS ticks
   // while DOOR persists, held untouched in every other mode.
   always_ff @(posedge clk) begin
      if (!rstN) begin
         r_sec_cnt  <= '0;
         r_door_bcd <= '0;
      end else if (w_mode_chg && (w_mode_next == MODE_DOOR)) begin
         r_sec_cnt  <= '0;
         r_door_bcd <= '0;
      end else if (!w_mode_chg && (r_mode == MODE_DOOR) && w_tick) begin
         if (r_sec_cnt == SEC_MAX) begin
            r_sec_cnt  <= '0;
            r_door_bcd <= bcd_inc_sat(r_door_bcd);
         end else begin
            r_sec_cnt <= r_sec_cnt + SEC_W'(1);
         end
      end
   end

   assign ledL      = r_led_l;
   assign ledR      = r_led_r;
   assign modeOut   = r_mode;
   assign doorTens  = r_door_bcd.tens;
   assign doorUnits = r_door_bcd.units;
   assign tick      = w_tick;

endmodule

// File: tb/tb_lamp_arbiter.sv
// Bench for lamp_arbiter with TICK_DIV=4, SEC_TICKS=2.
module tb_lamp_arbiter;

   localparam int W = 17;  // {mode, ledL, ledR, tens, units}

   logic       clk = 1'b0;
   logic       rstN;
   logic       reqL, reqR, reqBrake, reqDoor;
   logic [2:0] ledL, ledR, modeOut;
   logic [3:0] doorTens, doorUnits;
   logic       tick;

   int n_chk = 0;
   int n_err = 0;

   logic [W-1:0] exp_q[$];

   typedef struct {
      logic       l, r, b, d;
      int         cyc;
      logic [2:0] mode, led_l, led_r;
      logic [3:0] tens, units;
   } vec_t;

   vec_t vecs[$];

   lamp_arbiter #(
      .TICK_DIV  (4),
      .SEC_TICKS (2)
   ) dut (
      .clk       (clk),
      .rstN      (rstN),
      .reqL      (reqL),
      .reqR      (reqR),
      .reqBrake  (reqBrake),
      .reqDoor   (reqDoor),
      .ledL      (ledL),
      .ledR      (ledR),
      .modeOut   (modeOut),
      .doorTens  (doorTens),
      .doorUnits (doorUnits),
      .tick      (tick)
   );

   // Clock and watchdog
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Driver tasks
   task automatic wait_cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic l, input logic r, input logic b, input logic d);
      reqL     = l;
      reqR     = r;
      reqBrake = b;
      reqDoor  = d;
   endtask

   function automatic void add_vec(input logic l, input logic r, input logic b, input logic d,
                                   input int cyc, input logic [2:0] mode,
                                   input logic [2:0] led_l, input logic [2:0] led_r,
                                   input logic [3:0] tens, input logic [3:0] units);
      vec_t v;
      v.l = l; v.r = r; v.b = b; v.d = d; v.cyc = cyc;
      v.mode = mode; v.led_l = led_l; v.led_r = led_r; v.tens = tens; v.units = units;
      vecs.push_back(v);
   endfunction

   // Scoreboard: pop the oldest expectation and compare against the outputs.
   task automatic check_out(input string name);
      logic [W-1:0] exp_w, act_w;
      n_chk++;
      if (exp_q.size() == 0) begin
         n_err++;
         $display("FAIL %s: scoreboard queue empty", name);
      end else begin
         exp_w = exp_q.pop_front();
         act_w = {modeOut, ledL, ledR, doorTens, doorUnits};
         if (act_w !== exp_w) begin
            n_err++;
            $display("FAIL %s: mode/ledL/ledR/tens/units got %0d/%b/%b/%0d/%0d want %0d/%b/%b/%0d/%0d",
                     name, act_w[16:14], act_w[13:11], act_w[10:8], act_w[7:4], act_w[3:0],
                     exp_w[16:14], exp_w[13:11], exp_w[10:8], exp_w[7:4], exp_w[3:0]);
         end
      end
   endtask

   task automatic expect_wait(input string name, input int cyc, input logic [2:0] mode,
                              input logic [2:0] led_l, input logic [2:0] led_r,
                              input logic [3:0] tens, input logic [3:0] units);
      exp_q.push_back({mode, led_l, led_r, tens, units});
      wait_cyc(cyc);
      check_out(name);
   endtask

   task automatic check_tick(input string name, input logic exp_t);
      n_chk++;
      if (tick !== exp_t) begin
         n_err++;
         $display("FAIL %s: tick got %b want %b", name, tick, exp_t);
      end
   endtask

   initial begin
      // Vector table: inputs, cycles to wait, expected outputs after the wait.
      //      L  R  B  D  cyc  mode  ledL    ledR    T  U
      add_vec(0, 1, 0, 0,   2, 3'd2, 3'b000, 3'b001, 0, 0);  // right turn entry
      add_vec(0, 1, 0, 0,   4, 3'd2, 3'b000, 3'b011, 0, 0);
      add_vec(0, 1, 0, 0,   4, 3'd2, 3'b000, 3'b111, 0, 0);
      add_vec(0, 1, 0, 0,   4, 3'd2, 3'b000, 3'b000, 0, 0);
      add_vec(0, 1, 0, 0,   4, 3'd2, 3'b000, 3'b001, 0, 0);  // wrap 3->0
      add_vec(0, 1, 0, 0,   3, 3'd2, 3'b000, 3'b001, 0, 0);  // last cycle of step
      add_vec(0, 1, 0, 0,   1, 3'd2, 3'b000, 3'b011, 0, 0);
      add_vec(1, 0, 1, 0,   2, 3'd1, 3'b001, 3'b111, 0, 0);  // left + brake, restarts mid-step
      add_vec(1, 0, 1, 0,   4, 3'd1, 3'b011, 3'b111, 0, 0);
      add_vec(1, 0, 1, 0,   4, 3'd1, 3'b111, 3'b111, 0, 0);
      add_vec(1, 1, 1, 0,   2, 3'd3, 3'b001, 3'b001, 0, 0);  // hazard ignores brake
      add_vec(1, 1, 1, 0,   4, 3'd3, 3'b011, 3'b011, 0, 0);
      add_vec(1, 1, 1, 0,   2, 3'd3, 3'b011, 3'b011, 0, 0);  // mid-step
      add_vec(1, 1, 1, 1,   2, 3'd5, 3'b111, 3'b111, 0, 0);  // door entry
      add_vec(1, 1, 1, 1,   3, 3'd5, 3'b111, 3'b111, 0, 0);
      add_vec(1, 1, 1, 1,   1, 3'd5, 3'b000, 3'b000, 0, 0);  // first invert
      add_vec(1, 1, 1, 1,   4, 3'd5, 3'b111, 3'b111, 0, 1);  // one second
      add_vec(1, 1, 1, 1, 800, 3'd5, 3'b111, 3'b111, 9, 9);  // 202 ticks: saturated
      add_vec(1, 1, 1, 0,   2, 3'd3, 3'b001, 3'b001, 9, 9);  // timer held after exit
      add_vec(0, 0, 1, 0,   2, 3'd4, 3'b111, 3'b111, 9, 9);  // brake only
      add_vec(0, 0, 0, 0,   2, 3'd0, 3'b000, 3'b000, 9, 9);  // idle
      add_vec(0, 0, 0, 1,   2, 3'd5, 3'b111, 3'b111, 0, 0);  // re-entry clears timer
      add_vec(0, 0, 0, 1,   8, 3'd5, 3'b111, 3'b111, 0, 1);
      add_vec(0, 1, 1, 0,   2, 3'd2, 3'b111, 3'b001, 0, 1);  // right + brake
      add_vec(1, 1, 0, 0,   2, 3'd3, 3'b001, 3'b001, 0, 1);
      add_vec(1, 1, 0, 0,   8, 3'd3, 3'b111, 3'b111, 0, 1);  // hazard at step 2

      // Reset with every request high
      rstN = 1'b0;
      drive(1, 1, 1, 1);
      expect_wait("reset_all_req", 2, 3'd0, 3'b000, 3'b000, 0, 0);
      check_tick("reset_tick", 1'b0);
      drive(0, 0, 0, 0);
      wait_cyc(1);
      rstN = 1'b1;
      expect_wait("idle_after_reset", 3, 3'd0, 3'b000, 3'b000, 0, 0);

      // Table-driven sequence
      foreach (vecs[i]) begin
         drive(vecs[i].l, vecs[i].r, vecs[i].b, vecs[i].d);
         exp_q.push_back({vecs[i].mode, vecs[i].led_l, vecs[i].led_r, vecs[i].tens, vecs[i].units});
         wait_cyc(vecs[i].cyc);
         check_out($sformatf("vec%0d", i));
      end

      // Reset mid-hazard at step 2 with a non-zero door timer
      rstN = 1'b0;
      drive(1, 1, 1, 1);
      expect_wait("reset_mid_hazard", 1, 3'd0, 3'b000, 3'b000, 0, 0);
      drive(1, 1, 0, 0);
      wait_cyc(1);
      rstN = 1'b1;
      expect_wait("release_plus1", 1, 3'd0, 3'b000, 3'b000, 0, 0);
      expect_wait("release_plus2", 1, 3'd3, 3'b001, 3'b001, 0, 0);
      wait_cyc(2);
      check_tick("tick_low_before", 1'b0);
      wait_cyc(1);
      check_tick("tick_strobe", 1'b1);
      expect_wait("release_step1", 1, 3'd3, 3'b011, 3'b011, 0, 0);
      check_tick("tick_after", 1'b0);

      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL scoreboard_drain: %0d entries left want 0", exp_q.size());
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
